// File: rtl/output_serializer_if.sv
// Vector-in / word-out stream bundle for output_serializer. The master side is the serializer;
// the slave side feeds vectors and drains beats.
interface output_serializer_if #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_CHAINS = 4,
   parameter int DROP_WIDTH = 16
);
   localparam int CW = $clog2(MAX_CHAINS);
   localparam int IW = $clog2(N);

   logic                  valid_in;
   logic                  eof_in;
   logic [CW-1:0]         chainId_in;
   logic [DATA_WIDTH-1:0] vector_in [N-1:0];

   logic [DATA_WIDTH-1:0] word_out;
   logic                  word_valid;
   logic                  word_ready;
   logic [IW-1:0]         word_index;
   logic                  word_last;
   logic                  word_eof;
   logic [CW-1:0]         word_chainId;

   logic                  full;
   logic [DROP_WIDTH-1:0] drop_count;

   modport master (
      input  valid_in, eof_in, chainId_in, vector_in, word_ready,
      output word_out, word_valid, word_index, word_last, word_eof, word_chainId,
      output full, drop_count
   );

   modport slave (
      output valid_in, eof_in, chainId_in, vector_in, word_ready,
      input  word_out, word_valid, word_index, word_last, word_eof, word_chainId,
      input  full, drop_count
   );
endinterface

// File: rtl/output_serializer.sv
// Queues tagged N-element vectors in an OB_DEPTH-entry circular buffer and drains them
// one element per beat onto a valid/ready word stream; overflowing vectors are counted and dropped.
module output_serializer #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int OB_DEPTH   = 4,
   parameter int MAX_CHAINS = 4,
   parameter int DROP_WIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   output_serializer_if.master bus
);
   localparam int CW = $clog2(MAX_CHAINS);
   localparam int IW = $clog2(N);
   localparam int PW = $clog2(OB_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
   localparam logic [PW:0]   DEPTH    = (PW + 1)'(OB_DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state_reg;
   logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
   logic [PW:0]           count_reg;
   logic [IW-1:0]         idx_reg;
   logic [IW-1:0]         idx_next;
   logic                  hold_eof_reg;
   logic [DATA_WIDTH-1:0] hold_vec_reg [N-1:0];
   logic [DATA_WIDTH-1:0] head_vec [N-1:0];
   logic                  head_eof;
   logic [CW-1:0]         head_chain;
   logic                  mem_eof [OB_DEPTH];
   logic [CW-1:0]         mem_chain [OB_DEPTH];

   logic                  word_valid_reg, word_last_reg, word_eof_reg;
   logic [DATA_WIDTH-1:0] word_out_reg;
   logic [CW-1:0]         word_chainId_reg;
   logic [DROP_WIDTH-1:0] drop_count_reg;

   logic full, pop, push, drop;

   assign full     = (count_reg == DEPTH);
   // Pop either to start from idle or to chain the next vector straight after the last beat.
   assign pop      = (count_reg != '0) &&
                     ((state_reg == IDLE) ||
                      (state_reg == SEND && bus.word_ready && idx_reg == LAST_IDX));
   assign push     = bus.valid_in && (!full || pop);
   assign drop     = bus.valid_in && full && !pop;
   assign idx_next = idx_reg + IW'(1);

   assign head_eof   = mem_eof[rd_ptr_reg];
   assign head_chain = mem_chain[rd_ptr_reg];

   // One storage lane and one holding lane per element.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_mem [OB_DEPTH];

      always_ff @(posedge clk) begin
         if (push) lane_mem[wr_ptr_reg] <= bus.vector_in[gi];
      end

      assign head_vec[gi] = lane_mem[rd_ptr_reg];

      always_ff @(posedge clk or posedge reset) begin
         if (reset)    hold_vec_reg[gi] <= '0;
         else if (pop) hold_vec_reg[gi] <= head_vec[gi];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_eof[wr_ptr_reg]   <= bus.eof_in;
         mem_chain[wr_ptr_reg] <= bus.chainId_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         drop_count_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (PW + 1)'(1);
            2'b01:   count_reg <= count_reg - (PW + 1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (drop && drop_count_reg != '1) drop_count_reg <= drop_count_reg + DROP_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         idx_reg          <= '0;
         hold_eof_reg     <= 1'b0;
         word_valid_reg   <= 1'b0;
         word_out_reg     <= '0;
         word_last_reg    <= 1'b0;
         word_eof_reg     <= 1'b0;
         word_chainId_reg <= '0;
      end else if (pop) begin
         state_reg        <= SEND;
         idx_reg          <= '0;
         hold_eof_reg     <= head_eof;
         word_valid_reg   <= 1'b1;
         word_out_reg     <= head_vec[0];
         word_last_reg    <= (LAST_IDX == '0);
         word_eof_reg     <= head_eof && (LAST_IDX == '0);
         word_chainId_reg <= head_chain;
      end else if (state_reg == SEND && bus.word_ready) begin
         if (idx_reg == LAST_IDX) begin
            state_reg      <= IDLE;
            word_valid_reg <= 1'b0;
            word_last_reg  <= 1'b0;
            word_eof_reg   <= 1'b0;
         end else begin
            idx_reg       <= idx_next;
            word_out_reg  <= hold_vec_reg[idx_next];
            word_last_reg <= (idx_next == LAST_IDX);
            word_eof_reg  <= hold_eof_reg && (idx_next == LAST_IDX);
         end
      end
   end

   assign bus.word_valid   = word_valid_reg;
   assign bus.word_out     = word_out_reg;
   assign bus.word_index   = idx_reg;
   assign bus.word_last    = word_last_reg;
   assign bus.word_eof     = word_eof_reg;
   assign bus.word_chainId = word_chainId_reg;
   assign bus.full         = full;
   assign bus.drop_count   = drop_count_reg;
endmodule
